// File: rtl/id_register_file_sb.sv
// Decode-stage register file with write-back bypass and a per-register
// in-flight write scoreboard that raises a stall on RAW hazards or a full counter.
module id_register_file_sb #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 15,
    parameter int ADDR_W   = 4,
    parameter int CNT_W    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] src1,
    input  logic [ADDR_W-1:0] src2,
    input  logic              src1_used,
    input  logic              src2_used,
    output logic [DATA_W-1:0] reg1,
    output logic [DATA_W-1:0] reg2,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_dest,
    input  logic [DATA_W-1:0] wb_value,
    input  logic              issue_en,
    input  logic [ADDR_W-1:0] issue_dest,
    input  logic              flush,
    output logic              hazard,
    output logic              sb_err
);

    // One extra bit so NUM_REGS == 2^ADDR_W still compares correctly.
    localparam logic [ADDR_W:0] NUM_REGS_X = NUM_REGS[ADDR_W:0];

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [CNT_W-1:0]  cnt  [NUM_REGS];

    logic             s1_ok, s2_ok, wb_ok, iss_ok;
    logic [CNT_W-1:0] cnt_s1, cnt_s2, cnt_wb, cnt_iss;
    logic             dec, inc, same_reg;
    logic             raw1, raw2, full;

    assign s1_ok  = {1'b0, src1}       < NUM_REGS_X;
    assign s2_ok  = {1'b0, src2}       < NUM_REGS_X;
    assign wb_ok  = wb_en & ({1'b0, wb_dest} < NUM_REGS_X);
    assign iss_ok = {1'b0, issue_dest} < NUM_REGS_X;

    always_comb begin
        cnt_s1  = '0;
        cnt_s2  = '0;
        cnt_wb  = '0;
        cnt_iss = '0;
        if (s1_ok)  cnt_s1  = cnt[src1];
        if (s2_ok)  cnt_s2  = cnt[src2];
        if (wb_ok)  cnt_wb  = cnt[wb_dest];
        if (iss_ok) cnt_iss = cnt[issue_dest];
    end

    always_comb begin
        reg1 = '0;
        reg2 = '0;
        if (s1_ok) reg1 = (wb_en && wb_dest == src1) ? wb_value : regs[src1];
        if (s2_ok) reg2 = (wb_en && wb_dest == src2) ? wb_value : regs[src2];
    end

    assign dec      = wb_ok & (cnt_wb != '0);
    assign same_reg = (issue_dest == wb_dest);

    // A source whose last outstanding write lands this cycle is served by the bypass.
    assign raw1 = src1_used & s1_ok & (cnt_s1 != '0)
                & ~(dec & (wb_dest == src1) & (cnt_s1 == CNT_W'(1)));
    assign raw2 = src2_used & s2_ok & (cnt_s2 != '0)
                & ~(dec & (wb_dest == src2) & (cnt_s2 == CNT_W'(1)));
    assign full = issue_en & iss_ok & (cnt_iss == '1) & ~(dec & same_reg);

    assign hazard = raw1 | raw2 | full;
    assign inc    = issue_en & iss_ok & ~hazard;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= DATA_W'(i);
                cnt[i]  <= '0;
            end
            sb_err <= 1'b0;
        end else begin
            if (wb_ok) regs[wb_dest] <= wb_value;
            if (flush) begin
                for (int i = 0; i < NUM_REGS; i++) cnt[i] <= '0;
            end else begin
                if (inc && !(dec && same_reg)) cnt[issue_dest] <= cnt_iss + CNT_W'(1);
                if (dec && !(inc && same_reg)) cnt[wb_dest]    <= cnt_wb - CNT_W'(1);
                if (wb_ok && cnt_wb == '0)     sb_err          <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_id_register_file_sb.sv
// Bench for id_register_file_sb: directed scenarios plus random traffic,
// all checked against a behavioural model of registers and pending-write counts.
module tb_id_register_file_sb;

    localparam int NR   = 15;
    localparam int CMAX = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  src1, src2, wb_dest, issue_dest;
    logic        src1_used, src2_used, wb_en, issue_en, flush;
    logic [31:0] wb_value, reg1, reg2;
    logic        hazard, sb_err;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] m_reg [16];
    int          m_cnt [16];
    bit          m_err;

    id_register_file_sb dut (
        .clk(clk), .rst(rst),
        .src1(src1), .src2(src2), .src1_used(src1_used), .src2_used(src2_used),
        .reg1(reg1), .reg2(reg2),
        .wb_en(wb_en), .wb_dest(wb_dest), .wb_value(wb_value),
        .issue_en(issue_en), .issue_dest(issue_dest),
        .flush(flush), .hazard(hazard), .sb_err(sb_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_reg[i] = 32'(i);
            m_cnt[i] = 0;
        end
        m_err = 1'b0;
    endtask

    function automatic logic [31:0] exp_read(input logic [3:0] a);
        if (int'(a) >= NR) return 32'h0;
        if (wb_en && wb_dest == a) return wb_value;
        return m_reg[a];
    endfunction

    // Pending writes to r as seen this cycle, net of a retiring write-back.
    function automatic int eff_cnt(input logic [3:0] r);
        int c = m_cnt[r];
        if (wb_en && int'(wb_dest) < NR && m_cnt[wb_dest] > 0 && wb_dest == r) c--;
        return c;
    endfunction

    task automatic idle();
        rst = 0; src1 = 0; src2 = 0; src1_used = 0; src2_used = 0;
        wb_en = 0; wb_dest = 0; wb_value = 0; issue_en = 0; issue_dest = 0; flush = 0;
    endtask

    // Check outputs against the model for the current inputs, clock once, advance the model.
    task automatic step();
        bit hz, dec_v, inc_v, under, full_v;
        #1;
        dec_v  = wb_en && int'(wb_dest) < NR && m_cnt[wb_dest] > 0;
        under  = wb_en && int'(wb_dest) < NR && m_cnt[wb_dest] == 0;
        full_v = issue_en && int'(issue_dest) < NR && m_cnt[issue_dest] == CMAX
                 && !(dec_v && wb_dest == issue_dest);
        hz = (src1_used && int'(src1) < NR && eff_cnt(src1) != 0)
          || (src2_used && int'(src2) < NR && eff_cnt(src2) != 0)
          || full_v;
        inc_v = issue_en && int'(issue_dest) < NR && !hz;
        check("reg1", reg1, exp_read(src1));
        check("reg2", reg2, exp_read(src2));
        check("hazard", hazard, hz);
        check("sb_err", sb_err, m_err);
        @(posedge clk);
        if (rst) model_reset();
        else begin
            if (wb_en && int'(wb_dest) < NR) m_reg[wb_dest] = wb_value;
            if (flush) for (int i = 0; i < 16; i++) m_cnt[i] = 0;
            else begin
                if (inc_v) m_cnt[issue_dest]++;
                if (dec_v) m_cnt[wb_dest]--;
                if (under) m_err = 1'b1;
            end
        end
        #1;
    endtask

    initial begin
        idle();
        rst = 1;
        @(posedge clk);
        model_reset();
        #1;
        rst = 0;

        // Reset values
        src1 = 3; src2 = 14; src1_used = 1; src2_used = 1;
        #1;
        check("rst_reg1", reg1, 32'd3);
        check("rst_reg2", reg2, 32'd14);
        check("rst_hazard", hazard, 1'b0);
        check("rst_sb_err", sb_err, 1'b0);
        step();
        src1 = 15;
        #1; check("unimpl_read", reg1, 32'd0);
        step();

        // Bypass (R5 issued first so the write-back is not an underflow)
        idle(); issue_en = 1; issue_dest = 5; step();
        idle(); wb_en = 1; wb_dest = 5; wb_value = 32'hDEADBEEF; src1 = 5; src1_used = 1;
        #1;
        check("bypass_reg1", reg1, 32'hDEADBEEF);
        check("bypass_hazard", hazard, 1'b0);
        step();
        wb_en = 0;
        #1; check("stored_reg1", reg1, 32'hDEADBEEF);
        step();
        wb_en = 1; wb_dest = 15; wb_value = 32'h1234; src1 = 15; step();
        wb_en = 0; src1 = 5;
        #1; check("wb15_ignored", reg1, 32'hDEADBEEF);
        step();

        // RAW stall and release
        idle(); issue_en = 1; issue_dest = 2; step();
        idle(); src1 = 2; src1_used = 1;
        #1; check("raw_stall", hazard, 1'b1);
        step();
        src1_used = 0;
        #1; check("raw_unused", hazard, 1'b0);
        step();
        src1_used = 1; wb_en = 1; wb_dest = 2; wb_value = 32'hA5A5A5A5;
        #1;
        check("raw_release", hazard, 1'b0);
        check("raw_bypass", reg1, 32'hA5A5A5A5);
        step();
        wb_en = 0;
        #1; check("raw_cleared", hazard, 1'b0);
        step();

        // Counter saturation
        idle(); issue_en = 1; issue_dest = 4;
        repeat (3) step();
        #1; check("full_stall", hazard, 1'b1);
        step();
        wb_en = 1; wb_dest = 4; wb_value = 32'h44;
        #1; check("full_cancel", hazard, 1'b0);
        step();
        wb_en = 0;
        #1; check("still_full", hazard, 1'b1);
        step();

        // Flush with concurrent write-back
        idle(); flush = 1; step();
        idle(); issue_en = 1; issue_dest = 1; step(); step();
        issue_dest = 7; step();
        idle(); flush = 1; wb_en = 1; wb_dest = 1; wb_value = 32'h55; step();
        idle(); src1 = 1; src1_used = 1; src2 = 7; src2_used = 1;
        #1;
        check("flush_hazard", hazard, 1'b0);
        check("flush_reg1", reg1, 32'h55);
        check("flush_sb_err", sb_err, 1'b0);
        step();

        // Underflow, then reset together with an issue
        idle(); wb_en = 1; wb_dest = 9; wb_value = 32'h99; step();
        idle(); src1 = 9;
        #1;
        check("uf_sb_err", sb_err, 1'b1);
        check("uf_reg9", reg1, 32'h99);
        step(); step();
        #1; check("uf_sticky", sb_err, 1'b1);
        rst = 1; issue_en = 1; issue_dest = 3; step();
        idle(); src1 = 9; src2 = 3; src2_used = 1;
        #1;
        check("rst2_sb_err", sb_err, 1'b0);
        check("rst2_reg9", reg1, 32'd9);
        check("rst2_cnt3", hazard, 1'b0);
        step();

        // Random traffic
        for (int n = 0; n < 1500; n++) begin
            rst        = ($urandom_range(0, 199) == 0);
            flush      = ($urandom_range(0, 29) == 0);
            src1       = 4'($urandom_range(0, 15));
            src2       = 4'($urandom_range(0, 15));
            src1_used  = 1'($urandom_range(0, 1));
            src2_used  = 1'($urandom_range(0, 1));
            wb_en      = ($urandom_range(0, 9) < 4);
            wb_dest    = 4'($urandom_range(0, 15));
            wb_value   = $urandom;
            issue_en   = ($urandom_range(0, 9) < 5);
            issue_dest = 4'($urandom_range(0, 15));
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
